// File: rtl/shared_port_arbiter_pkg.sv
// rtl/shared_port_arbiter_pkg.sv - shared types and defaults for the two-port round-robin arbiter
package shared_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT   = 5;

endpackage

// File: rtl/shared_port_arbiter_timeout.sv
// rtl/shared_port_arbiter_timeout.sv - grant-duration counter with terminal-count flag
module arb_timeout_counter
  import shared_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over enable so every fresh grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count marks the last cycle a grant may stay open.
  always_comb begin
    tc = (cnt == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// rtl/shared_port_arbiter.sv - two-requester round-robin arbiter with per-grant timeout
module shared_port_arbiter
  import shared_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic active,
  output logic timeout_err
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_served_q;
  logic       last_served_d;
  logic       timeout_err_d;
  logic       sel_d;
  logic       cnt_clr;
  logic       cnt_en;
  logic       tc;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  // Next-state decode: round-robin tie break in IDLE, release/handover while owning.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    timeout_err_d = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_served_q ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
        cnt_clr = (state_d != ST_IDLE);
      end
      ST_OWN0: begin
        if (done || !req0 || tc) begin
          last_served_d = 1'b0;
          // A done or an abandon in the terminal cycle is a normal release.
          timeout_err_d = tc && !done && req0;
          cnt_clr       = 1'b1;
          if (req1) begin
            state_d = ST_OWN1;
          end else if (done && req0) begin
            state_d = ST_OWN0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_OWN1: begin
        if (done || !req1 || tc) begin
          last_served_d = 1'b1;
          timeout_err_d = tc && !done && req1;
          cnt_clr       = 1'b1;
          if (req0) begin
            state_d = ST_OWN0;
          end else if (done && req1) begin
            state_d = ST_OWN1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Mux select follows the owner and holds its last value while idle.
  always_comb begin
    sel_d = sel;
    if (state_d == ST_OWN1) begin
      sel_d = 1'b1;
    end else if (state_d == ST_OWN0) begin
      sel_d = 1'b0;
    end
  end

  // State, round-robin pointer and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_served_q <= 1'b1;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      sel           <= 1'b0;
      active        <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      gnt0          <= (state_d == ST_OWN0);
      gnt1          <= (state_d == ST_OWN1);
      sel           <= sel_d;
      active        <= (state_d != ST_IDLE);
      timeout_err   <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb/tb_shared_port_arbiter.sv - directed vector bench for shared_port_arbiter
module tb_shared_port_arbiter;

  logic clk;
  logic rst_n;
  logic req0;
  logic req1;
  logic done;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic active;
  logic timeout_err;

  int n_vec;
  int n_bad;

  // Expected output word layout: {gnt0, gnt1, sel, active, timeout_err}
  typedef struct {
    logic       r0;
    logic       r1;
    logic       d;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[21];

  shared_port_arbiter #(
    .TIMEOUT (16),
    .CNT_W   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .req1        (req1),
    .done        (done),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .sel         (sel),
    .active      (active),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r0, logic r1, logic d, logic [4:0] e);
    vec_t v;
    v.r0  = r0;
    v.r1  = r1;
    v.d   = d;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {gnt0, gnt1, sel, active, timeout_err};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got g0g1/sel/act/err=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r0, input logic r1, input logic d);
    req0 = r0;
    req1 = r1;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0  = 1'b0;
    req1  = 1'b0;
    done  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int owner;
    n_vec = 0;
    n_bad = 0;

    tbl[0]  = mk(0, 0, 0, 5'b00000);
    tbl[1]  = mk(1, 0, 0, 5'b10010);
    tbl[2]  = mk(1, 0, 0, 5'b10010);
    tbl[3]  = mk(1, 0, 0, 5'b10010);
    tbl[4]  = mk(0, 0, 1, 5'b00000);
    tbl[5]  = mk(1, 0, 0, 5'b10010);
    tbl[6]  = mk(1, 0, 1, 5'b10010);
    tbl[7]  = mk(1, 1, 0, 5'b10010);
    tbl[8]  = mk(0, 1, 0, 5'b01110);
    tbl[9]  = mk(1, 1, 1, 5'b10010);
    tbl[10] = mk(0, 0, 0, 5'b00000);
    tbl[11] = mk(0, 1, 0, 5'b01110);
    tbl[12] = mk(0, 0, 0, 5'b00100);
    tbl[13] = mk(0, 0, 1, 5'b00100);
    tbl[14] = mk(1, 1, 0, 5'b10010);
    tbl[15] = mk(1, 1, 1, 5'b01110);
    tbl[16] = mk(1, 1, 0, 5'b01110);
    tbl[17] = mk(1, 1, 1, 5'b10010);
    tbl[18] = mk(1, 1, 0, 5'b10010);
    tbl[19] = mk(1, 0, 0, 5'b10010);
    tbl[20] = mk(0, 0, 0, 5'b00000);

    do_reset();
    chk("reset_state", 5'b00000);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r0, tbl[i].r1, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Both requesting continuously, done every third cycle: strict alternation.
    do_reset();
    step(1, 1, 0);
    chk("alt_first", 5'b10010);
    owner = 0;
    for (int c = 1; c <= 12; c++) begin
      logic d;
      d = ((c % 3) == 0);
      step(1, 1, d);
      if (d) owner = 1 - owner;
      chk($sformatf("alt_c%0d", c),
          (owner == 0) ? 5'b10010 : 5'b01110);
    end

    // Timeout: req1 alone, no done; 16 granted cycles then one error cycle.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0);
      chk($sformatf("to_hold%0d", k), 5'b01110);
    end
    step(0, 1, 0);
    chk("to_err", 5'b00101);
    step(0, 1, 0);
    chk("to_regrant", 5'b01110);

    // done on the terminal cycle: normal release, re-grant, counter restarted.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0);
    end
    chk("tc_pre", 5'b01110);
    step(0, 1, 1);
    chk("tc_done_no_err", 5'b01110);
    for (int k = 1; k <= 15; k++) begin
      step(0, 1, 0);
    end
    chk("tc_counter_restart", 5'b01110);
    step(0, 1, 0);
    chk("tc_second_timeout", 5'b00101);

    // Async reset mid-OWN1, after last_served was moved to requester 0.
    do_reset();
    step(1, 0, 0);
    chk("rst_own0", 5'b10010);
    step(0, 1, 0);
    chk("rst_own1", 5'b01110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", 5'b00000);
    req0 = 1'b1;
    req1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_held", 5'b00000);
    rst_n = 1'b1;
    step(1, 1, 0);
    chk("rst_tie_to_0", 5'b10010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
